// File: rtl/xor_checksum_unit.sv
// Frame XOR checksum: accumulates beats until in_last or MAX_WORDS, then holds the result.
// Optional XOR_CHECKSUM_COMPARE_EN adds exp_chk/out_err comparison against an expected checksum.
module xor_checksum_unit #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_WORDS = 16,
   localparam int unsigned CW       = $clog2(MAX_WORDS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_chk,
   output logic [CW-1:0]    out_cnt,
   output logic             out_ovf,
   output logic             out_valid,
   input  logic             out_ready
`ifdef XOR_CHECKSUM_COMPARE_EN
   ,
   input  logic [WIDTH-1:0] exp_chk,
   output logic             out_err
`endif
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACCUM = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             rdy_q;
   logic             accept;
   logic [WIDTH-1:0] acc_upd;
   logic [CW-1:0]    cnt_upd;

   // in_ready is registered so it stays low through reset and rises on the first edge after release
   assign in_ready  = rdy_q;
   assign accept    = in_valid && rdy_q;
   assign out_valid = (state_q == S_DONE);
   assign out_chk   = acc_q;
   assign out_cnt   = cnt_q;
   assign out_ovf   = ovf_q;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      acc_upd = (state_q == S_ACCUM) ? (acc_q ^ in_data) : in_data;
      cnt_upd = (state_q == S_ACCUM) ? (cnt_q + CW'(1)) : CW'(1);
      case (state_q)
         S_IDLE, S_ACCUM: begin
            if (accept) begin
               acc_d = acc_upd;
               cnt_d = cnt_upd;
               ovf_d = 1'b0;
               if (in_last) begin
                  state_d = S_DONE;
               end else if (cnt_upd == CW'(MAX_WORDS)) begin
                  state_d = S_DONE;
                  ovf_d   = 1'b1;
               end else begin
                  state_d = S_ACCUM;
               end
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         rdy_q   <= (state_d != S_DONE);
      end
   end

`ifdef XOR_CHECKSUM_COMPARE_EN
   logic err_q, err_d;

   assign out_err = err_q;

   // Overflow frames never saw their expected checksum, so they always flag an error
   always_comb begin
      err_d = err_q;
      if (accept && (state_q != S_DONE)) begin
         if (in_last)                       err_d = (acc_upd != exp_chk);
         else if (cnt_upd == CW'(MAX_WORDS)) err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end
`endif

endmodule

// File: tb/tb_xor_checksum_unit.sv
// Randomized and directed bench for xor_checksum_unit against a frame-level queue model.
module tb_xor_checksum_unit;
   localparam int W  = 8;
   localparam int MW = 4;
   localparam int CW = $clog2(MW + 1);

   logic          clk = 1'b0;
   logic          rst_n;
   logic [W-1:0]  in_data;
   logic          in_valid;
   logic          in_last;
   logic          in_ready;
   logic [W-1:0]  out_chk;
   logic [CW-1:0] out_cnt;
   logic          out_ovf;
   logic          out_valid;
   logic          out_ready;
`ifdef XOR_CHECKSUM_COMPARE_EN
   logic [W-1:0]  exp_chk;
   logic          out_err;
`endif

   xor_checksum_unit #(.WIDTH(W), .MAX_WORDS(MW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_chk   (out_chk),
      .out_cnt   (out_cnt),
      .out_ovf   (out_ovf),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef XOR_CHECKSUM_COMPARE_EN
      ,
      .exp_chk   (exp_chk),
      .out_err   (out_err)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] chk;
      int           cnt;
      bit           ovf;
      bit           err;
   } res_t;

   res_t         pend[$];
   logic [W-1:0] frame[$];
   bit           blocked;
   int           checks;
   int           failures;
   int           pops;
   logic [W-1:0] got_chk;
   int           got_cnt;
   bit           got_ovf;
   bit           got_err;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock: check at negedge, advance the model, return #1 after the posedge
   task automatic step(output bit acc);
      res_t         r;
      logic [W-1:0] x;
      bit           exp_rdy;
      @(negedge clk);
      acc = 1'b0;
      if (!rst_n) begin
         check_eq("rst_in_ready", in_ready, 0);
         check_eq("rst_out_valid", out_valid, 0);
         frame.delete();
         pend.delete();
         blocked = 1'b1;
      end else begin
         exp_rdy = !blocked && (pend.size() == 0);
         check_eq("in_ready", in_ready, exp_rdy);
         check_eq("out_valid", out_valid, pend.size() != 0);
         if (pend.size() != 0) begin
            check_eq("out_chk", out_chk, pend[0].chk);
            check_eq("out_cnt", out_cnt, pend[0].cnt);
            check_eq("out_ovf", out_ovf, pend[0].ovf);
`ifdef XOR_CHECKSUM_COMPARE_EN
            check_eq("out_err", out_err, pend[0].err);
`endif
            if (out_ready) begin
               got_chk = out_chk;
               got_cnt = int'(out_cnt);
               got_ovf = out_ovf;
`ifdef XOR_CHECKSUM_COMPARE_EN
               got_err = out_err;
`endif
               pops++;
               void'(pend.pop_front());
            end
         end
         acc = in_valid && exp_rdy;
         if (acc) begin
            frame.push_back(in_data);
            if (in_last || frame.size() == MW) begin
               x = '0;
               foreach (frame[i]) x = x ^ frame[i];
               r.chk = x;
               r.cnt = frame.size();
               r.ovf = !in_last;
               r.err = 1'b1;
`ifdef XOR_CHECKSUM_COMPARE_EN
               if (in_last) r.err = (x != exp_chk);
`endif
               pend.push_back(r);
               frame.delete();
            end
         end
         blocked = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [W-1:0] d, input logic last);
      bit a;
      bit done;
      done     = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      for (int i = 0; i < 50 && !done; i++) begin
         step(a);
         done = a;
      end
      check_eq("beat_accepted", done, 1);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_result();
      bit a;
      int prev;
      prev = pops;
      for (int i = 0; i < 50 && pops == prev; i++) step(a);
      check_eq("result_seen", pops != prev, 1);
   endtask

   initial begin
      bit a;
      bit acc_any;
      checks    = 0;
      failures  = 0;
      pops      = 0;
      blocked   = 1'b1;
      rst_n     = 1'b0;
      in_data   = '0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
`ifdef XOR_CHECKSUM_COMPARE_EN
      exp_chk   = '0;
`endif
      step(a);
      step(a);
      rst_n = 1'b1;
      step(a);

      send_beat(8'h3C, 1'b0);
      send_beat(8'hA5, 1'b0);
      send_beat(8'h0F, 1'b1);
      wait_result();
      check_eq("ex3_chk", got_chk, 8'h96);
      check_eq("ex3_cnt", got_cnt, 3);
      check_eq("ex3_ovf", got_ovf, 0);
      step(a);

      send_beat(8'h5A, 1'b1);
      wait_result();
      check_eq("single_chk", got_chk, 8'h5A);
      check_eq("single_cnt", got_cnt, 1);

      for (int i = 0; i < 4; i++) send_beat(8'h01, 1'b0);
      wait_result();
      check_eq("ovf_chk", got_chk, 8'h00);
      check_eq("ovf_cnt", got_cnt, 4);
      check_eq("ovf_flag", got_ovf, 1);
      send_beat(8'h01, 1'b0);
      send_beat(8'h01, 1'b1);
      wait_result();
      check_eq("ovf_next_cnt", got_cnt, 2);
      check_eq("ovf_next_ovf", got_ovf, 0);

      out_ready = 1'b0;
      send_beat(8'hAA, 1'b0);
      send_beat(8'h55, 1'b1);
      in_valid = 1'b1;
      in_data  = 8'h77;
      acc_any  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(a);
         acc_any = acc_any | a;
      end
      check_eq("stall_no_accept", acc_any, 0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_result();
      check_eq("stall_chk", got_chk, 8'hFF);
      check_eq("stall_cnt", got_cnt, 2);
      step(a);

      send_beat(8'hDE, 1'b0);
      send_beat(8'hAD, 1'b0);
      rst_n = 1'b0;
      #1;
      check_eq("async_in_ready", in_ready, 0);
      check_eq("async_out_valid", out_valid, 0);
      step(a);
      rst_n = 1'b1;
      step(a);
      send_beat(8'h11, 1'b0);
      send_beat(8'h22, 1'b1);
      wait_result();
      check_eq("post_rst_chk", got_chk, 8'h33);
      check_eq("post_rst_cnt", got_cnt, 2);

`ifdef XOR_CHECKSUM_COMPARE_EN
      send_beat(8'h0F, 1'b0);
      exp_chk = 8'hFF;
      send_beat(8'hF0, 1'b1);
      wait_result();
      check_eq("cmp_ok_err", got_err, 0);
      send_beat(8'h0F, 1'b0);
      exp_chk = 8'hFE;
      send_beat(8'hF0, 1'b1);
      wait_result();
      check_eq("cmp_bad_err", got_err, 1);
`endif

      for (int i = 0; i < 2000; i++) begin
         in_valid  = ($urandom_range(3) != 0);
         in_last   = ($urandom_range(3) == 0);
         in_data   = W'($urandom);
         out_ready = ($urandom_range(2) != 0);
`ifdef XOR_CHECKSUM_COMPARE_EN
         exp_chk   = ($urandom_range(1) == 0) ? W'($urandom) : out_chk;
`endif
         if ($urandom_range(299) == 0) begin
            rst_n = 1'b0;
            step(a);
            rst_n = 1'b1;
         end else begin
            step(a);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/xor_checksum_unit.md
XOR_CHECKSUM_UNIT -- requirements
Module: xor_checksum_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data and checksum width in bits (legal 1..64).
REQ-002 The block SHALL have parameter MAX_WORDS, default 16, maximum beats per frame (legal 2..1024).
REQ-003 The block SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port in_data, input, WIDTH, frame data beat.
REQ-006 The block SHALL have port in_valid, input, 1, in_data and in_last valid.
REQ-007 The block SHALL have port in_last, input, 1, final beat of frame.
REQ-008 The block SHALL have port in_ready, output, 1, block accepts a beat this cycle.
REQ-009 The block SHALL have port out_chk, output, WIDTH, XOR of all accepted beats of the frame.
REQ-010 The block SHALL have port out_cnt, output, CW = $clog2(MAX_WORDS+1), beats in the frame.
REQ-011 The block SHALL have port out_ovf, output, 1, frame force-terminated at MAX_WORDS.
REQ-012 The block SHALL have port out_valid, output, 1, result valid.
REQ-013 The block SHALL have port out_ready, input, 1, consumer accepts the result.

Function
REQ-014 The block SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-015 The block SHALL drive in_ready=1 in IDLE and ACCUM and in_ready=0 in DONE.
REQ-016 A beat SHALL be accepted only when in_valid && in_ready are both high in the same cycle.
REQ-017 In IDLE, an accepted beat SHALL load acc=in_data and cnt=1, then go to DONE if in_last, else to ACCUM.
REQ-018 In ACCUM, an accepted beat SHALL set acc=acc^in_data and cnt=cnt+1, then go to DONE if in_last.
REQ-019 If the accepted beat is the MAX_WORDS-th beat with in_last=0, the FSM SHALL go to DONE with ovf=1; the next beat starts a new frame.
REQ-020 A cycle with in_valid=0 SHALL leave acc, cnt and state unchanged.
REQ-021 In DONE, out_valid SHALL be 1 and out_chk/out_cnt/out_ovf SHALL hold stable until out_ready=1.
REQ-022 out_valid SHALL be 0 in IDLE and ACCUM; out_chk, out_cnt and out_ovf are don't-care when out_valid=0.
REQ-023 Latency: out_valid SHALL rise on the cycle after the final beat is accepted.
REQ-024 On the out_valid && out_ready handshake, the FSM SHALL return to IDLE and out_valid SHALL fall on the next cycle.
REQ-025 A single-beat frame SHALL give out_chk=in_data and out_cnt=1.
REQ-026 Maximum throughput SHALL be one frame every cnt+1 cycles, the extra cycle being the DONE bubble.

Reset
REQ-027 While rst_n=0, the block SHALL set state=IDLE, acc=0, cnt=0, ovf=0, out_valid=0 and in_ready=0, independent of clk.
REQ-028 Assertion of rst_n mid-frame or in DONE SHALL discard the partial frame or pending result without emitting it.
REQ-029 After rst_n deasserts, in_ready SHALL be 1 from the first clock edge.

Configuration
REQ-030 The block SHALL support macro XOR_CHECKSUM_COMPARE_EN.
REQ-031 With XOR_CHECKSUM_COMPARE_EN defined, the block SHALL add input exp_chk[WIDTH] and output out_err.
REQ-032 With XOR_CHECKSUM_COMPARE_EN defined, exp_chk SHALL be sampled with the accepted in_last beat.
REQ-033 With XOR_CHECKSUM_COMPARE_EN defined, out_err SHALL equal (final acc != exp_chk) and be valid with out_valid.
REQ-034 With XOR_CHECKSUM_COMPARE_EN defined, out_err SHALL be 1 on ovf frames.
REQ-035 With XOR_CHECKSUM_COMPARE_EN defined, out_err SHALL reset to 0.
REQ-036 Without XOR_CHECKSUM_COMPARE_EN, exp_chk and out_err SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-037 WIDTH=8, frame 0x3C,0xA5,0x0F (last), out_ready=1 -> out_chk=0x96, out_cnt=3, out_ovf=0, out_valid high one cycle.
REQ-038 Single beat 0x5A with in_last=1 -> next cycle out_valid=1, out_chk=0x5A, out_cnt=1.
REQ-039 MAX_WORDS=4, six beats of 0x01 with no in_last -> first result out_chk=0x00, out_cnt=4, out_ovf=1; second result pending, out_cnt=2 after a later in_last.
REQ-040 out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0, no beats accepted; release -> IDLE.
REQ-041 rst_n pulsed low after 2 beats of a frame -> no out_valid; new frame 0x11,0x22 (last) -> out_chk=0x33, out_cnt=2.
REQ-042 With XOR_CHECKSUM_COMPARE_EN, frame 0x0F,0xF0 (last), exp_chk=0xFF -> out_err=0; with exp_chk=0xFE -> out_err=1.
